// File: rtl/popcount_stream.sv
// Streaming two-stage population counter with valid/ready on both sides and a frame-accumulate mode.
// Optional feature macro: POPCOUNT_PARITY_EN adds out_parity (XOR of all data bits behind each result).
module popcount_stream #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_count,
    output logic              out_sat
`ifdef POPCOUNT_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    function automatic logic [CNT_W-1:0] f_popcount(input logic [DATA_W-1:0] d);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, d[i]};
        end
        return c;
    endfunction

`ifdef POPCOUNT_PARITY_EN
    function automatic logic f_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    logic             r_s1_valid;
    logic [CNT_W-1:0] r_s1_cnt;
    logic             r_s1_last;
    logic             r_s1_frame;
    logic             r_frame_open;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_count;
    logic             r_out_sat;
`ifdef POPCOUNT_PARITY_EN
    logic             r_s1_par;
    logic             r_acc_par;
    logic             r_out_parity;
    logic             w_res_par;
`endif

    logic             w_eff_frame;
    logic             w_s1_accum;
    logic             w_s2_take;
    logic             w_accept;
    logic             w_s1_fire;
    logic [ACC_W-1:0] w_cnt_ext;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_sum_sat;
    logic [ACC_W-1:0] w_res_count;
    logic             w_res_sat;

    // Handshake and datapath decode; mid-frame words always drain into the accumulator.
    always_comb begin
        w_eff_frame = r_frame_open | mode;
        w_s1_accum  = r_s1_valid & r_s1_frame & ~r_s1_last;
        w_s2_take   = w_s1_accum | ~r_out_valid | out_ready;
        in_ready    = rst_n & (~r_s1_valid | w_s2_take);
        w_accept    = in_valid & in_ready;
        w_s1_fire   = r_s1_valid & w_s2_take;
        w_cnt_ext   = ACC_W'(r_s1_cnt);
        w_sum       = {1'b0, r_acc} + {1'b0, w_cnt_ext};
        if (w_sum[ACC_W]) begin
            w_sum_sat = ACC_MAX;
        end else begin
            w_sum_sat = w_sum[ACC_W-1:0];
        end
        if (r_s1_frame) begin
            w_res_count = w_sum_sat;
            w_res_sat   = r_sat | w_sum[ACC_W];
        end else begin
            w_res_count = w_cnt_ext;
            w_res_sat   = 1'b0;
        end
`ifdef POPCOUNT_PARITY_EN
        if (r_s1_frame) begin
            w_res_par = r_acc_par ^ r_s1_par;
        end else begin
            w_res_par = r_s1_par;
        end
`endif
    end

    // Stage 1: capture the word's count and latch the effective mode for the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_cnt     <= {CNT_W{1'b0}};
            r_s1_last    <= 1'b0;
            r_s1_frame   <= 1'b0;
            r_frame_open <= 1'b0;
`ifdef POPCOUNT_PARITY_EN
            r_s1_par     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_s1_valid   <= 1'b1;
            r_s1_cnt     <= f_popcount(in_data);
            r_s1_last    <= in_last;
            r_s1_frame   <= w_eff_frame;
            r_frame_open <= w_eff_frame & ~in_last;
`ifdef POPCOUNT_PARITY_EN
            r_s1_par     <= f_parity(in_data);
`endif
        end else if (w_s1_fire) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Stage 2: accumulate mid-frame words, or present a result and restart the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= {ACC_W{1'b0}};
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_count <= {ACC_W{1'b0}};
            r_out_sat   <= 1'b0;
`ifdef POPCOUNT_PARITY_EN
            r_acc_par    <= 1'b0;
            r_out_parity <= 1'b0;
`endif
        end else if (w_s1_fire && !w_s1_accum) begin
            r_out_valid <= 1'b1;
            r_out_count <= w_res_count;
            r_out_sat   <= w_res_sat;
            r_acc       <= {ACC_W{1'b0}};
            r_sat       <= 1'b0;
`ifdef POPCOUNT_PARITY_EN
            r_out_parity <= w_res_par;
            r_acc_par    <= 1'b0;
`endif
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_s1_fire) begin
                r_acc <= w_sum_sat;
                r_sat <= r_sat | w_sum[ACC_W];
`ifdef POPCOUNT_PARITY_EN
                r_acc_par <= r_acc_par ^ r_s1_par;
`endif
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;
`ifdef POPCOUNT_PARITY_EN
    assign out_parity = r_out_parity;
`endif

endmodule

// File: tb/tb_popcount_stream.sv
// Self-checking bench for popcount_stream: a default instance (ACC_W=16) and a narrow one (ACC_W=6)
// share stimulus; a table of vectors plus hand-written backpressure and mid-frame reset sequences.
module tb_popcount_stream;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_last, mode, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_sat;
    logic [15:0] out_count;
    logic        in_ready6, out_valid6, out_sat6;
    logic [5:0]  out_count6;
`ifdef POPCOUNT_PARITY_EN
    logic        out_parity, out_parity6;
`endif

    always #5 clk = ~clk;

    popcount_stream #(.DATA_W(32), .ACC_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_sat(out_sat)
`ifdef POPCOUNT_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    popcount_stream #(.DATA_W(32), .ACC_W(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
        .in_data(in_data), .in_last(in_last), .mode(mode),
        .out_valid(out_valid6), .out_ready(out_ready), .out_count(out_count6), .out_sat(out_sat6)
`ifdef POPCOUNT_PARITY_EN
        , .out_parity(out_parity6)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        mode;
        logic        last;
        logic        emit;
        int          e16;
        logic        s16;
        int          e6;
        logic        s6;
        logic        par;
    } vec_t;

    typedef struct {
        int   e16;
        logic s16;
        int   e6;
        logic s6;
        logic par;
        int   cyc;
        logic lat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    vec_t tbl[22];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input vec_t v, input logic lat, input int c);
        exp_t e;
        if (v.emit) begin
            e.e16 = v.e16; e.s16 = v.s16; e.e6 = v.e6; e.s6 = v.s6;
            e.par = v.par; e.cyc = c; e.lat = lat;
            q.push_back(e);
        end
    endtask

    task automatic send(input vec_t v, input logic lat, output int waits);
        logic ok;
        int   c;
        bit   done;
        @(negedge clk);
        in_valid = 1'b1; in_data = v.data; mode = v.mode; in_last = v.last;
        waits = 0; done = 1'b0;
        while (!done) begin
            #4; ok = in_ready; c = cyc;
            @(posedge clk);
            if (ok) begin
                push_exp(v, lat, c);
                done = 1'b1;
            end else if (waits >= 50) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: in_ready stayed %0d, expected 1", ok);
                done = 1'b1;
            end else begin
                waits++;
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    // Output monitor: scoreboard pop on every transfer, plus hold-stability under backpressure.
    initial begin
        logic hold_pend;
        int   hold_cnt;
        exp_t e;
        hold_pend = 1'b0;
        hold_cnt  = 0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_count", out_count, hold_cnt);
                end
                hold_pend = out_valid && !out_ready;
                hold_cnt  = out_count;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_output: count %0d, expected no output", out_count);
                    end else begin
                        e = q.pop_front();
                        check("count16", out_count, e.e16);
                        check("sat16", out_sat, e.s16);
                        check("valid6", out_valid6, 1);
                        check("count6", out_count6, e.e6);
                        check("sat6", out_sat6, e.s6);
`ifdef POPCOUNT_PARITY_EN
                        check("parity16", out_parity, e.par);
                        check("parity6", out_parity6, e.par);
`endif
                        if (e.lat) check("latency", cyc - e.cyc, 2);
                    end
                end
            end
        end
    end

    initial begin
        int   w;
        int   accepts;
        logic ok;
        int   c;
        vec_t v;

        //            data          mode  last  emit  e16  s16   e6  s6    par
        tbl[0]  = '{32'h00000000, 1'b0, 1'b0, 1'b1,  0, 1'b0,  0, 1'b0, 1'b0};
        tbl[1]  = '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32, 1'b0, 32, 1'b0, 1'b0};
        tbl[2]  = '{32'h80000001, 1'b0, 1'b1, 1'b1,  2, 1'b0,  2, 1'b0, 1'b0};
        tbl[3]  = '{32'h12345678, 1'b0, 1'b0, 1'b1, 13, 1'b0, 13, 1'b0, 1'b1};
        tbl[4]  = '{32'hAAAAAAAA, 1'b0, 1'b0, 1'b1, 16, 1'b0, 16, 1'b0, 1'b0};
        tbl[5]  = '{32'h000000FF, 1'b1, 1'b0, 1'b0,  0, 1'b0,  0, 1'b0, 1'b0};
        tbl[6]  = '{32'h0000FFFF, 1'b1, 1'b0, 1'b0,  0, 1'b0,  0, 1'b0, 1'b0};
        tbl[7]  = '{32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 56, 1'b0, 56, 1'b0, 1'b0};
        tbl[8]  = '{32'h00000003, 1'b1, 1'b0, 1'b0,  0, 1'b0,  0, 1'b0, 1'b0};
        tbl[9]  = '{32'h00000001, 1'b1, 1'b1, 1'b1,  3, 1'b0,  3, 1'b0, 1'b1};
        tbl[10] = '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0,  0, 1'b0,  0, 1'b0, 1'b0};
        tbl[11] = '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0,  0, 1'b0,  0, 1'b0, 1'b0};
        tbl[12] = '{32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 96, 1'b0, 63, 1'b1, 1'b0};
        tbl[13] = '{32'h00000003, 1'b0, 1'b0, 1'b1,  2, 1'b0,  2, 1'b0, 1'b0};
        tbl[14] = '{32'h0000000F, 1'b1, 1'b0, 1'b0,  0, 1'b0,  0, 1'b0, 1'b0};
        tbl[15] = '{32'h000000F0, 1'b0, 1'b0, 1'b0,  0, 1'b0,  0, 1'b0, 1'b0};
        tbl[16] = '{32'h00000001, 1'b0, 1'b1, 1'b1,  9, 1'b0,  9, 1'b0, 1'b1};
        tbl[17] = '{32'h00000007, 1'b0, 1'b0, 1'b1,  3, 1'b0,  3, 1'b0, 1'b1};
        tbl[18] = '{32'h00000003, 1'b0, 1'b0, 1'b1,  2, 1'b0,  2, 1'b0, 1'b0};
        tbl[19] = '{32'h00000007, 1'b1, 1'b0, 1'b0,  0, 1'b0,  0, 1'b0, 1'b0};
        tbl[20] = '{32'h00000001, 1'b1, 1'b1, 1'b1,  4, 1'b0,  4, 1'b0, 1'b0};
        tbl[21] = '{32'h0000000F, 1'b1, 1'b1, 1'b1,  4, 1'b0,  4, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_count6", out_count6, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check("ready_after_reset", in_ready, 1);

        for (int i = 0; i < 22; i++) begin
            send(tbl[i], (i < 3) ? 1'b1 : 1'b0, w);
            if (i < 3) check("no_stall", w, 0);
        end
        wait_drain();

        // Backpressure: consumer stalls for five cycles while 0xF words stream in.
        v = '{32'h0000000F, 1'b0, 1'b0, 1'b1, 4, 1'b0, 4, 1'b0, 1'b0};
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = v.data; mode = 1'b0; in_last = 1'b0;
        accepts = 0;
        for (int k = 0; k < 5; k++) begin
            #4; ok = in_ready; c = cyc;
            @(posedge clk);
            if (ok) begin
                push_exp(v, 1'b0, c);
                accepts++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #4;
        check("bp_accepts", accepts, 2);
        check("bp_in_ready", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
        send(v, 1'b0, w);
        send(v, 1'b0, w);
        wait_drain();

        // Reset in the middle of an open frame discards the partial sum.
        send('{32'h000000FF, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0}, 1'b0, w);
        send('{32'h000000FF, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0}, 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #4;
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready_after", in_ready, 1);
        send('{32'h00000003, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0}, 1'b0, w);
        send('{32'h00000001, 1'b1, 1'b1, 1'b1, 3, 1'b0, 3, 1'b0, 1'b1}, 1'b0, w);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
